// File: rtl/fp_div_sqrt_issue_ctrl.sv
// In-order issue queue plus launch/capture control for the iterative FP32 divide/sqrt unit.
// Define FP_DIV_SQRT_FAST_SPECIAL_EN to resolve special-operand ops locally without the divider.
module fp_div_sqrt_issue_ctrl #(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned TAG_WIDTH   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_lhs,
  input  logic [31:0]          in_rhs,
  input  logic                 in_is_divide,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 flush,
  output logic                 div_req,
  output logic [31:0]          div_lhs,
  output logic [31:0]          div_rhs,
  output logic                 div_is_divide,
  input  logic                 div_finished,
  input  logic [31:0]          div_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [TAG_WIDTH-1:0] out_tag
);
  localparam int unsigned IDX_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned MEM_D = 1 << IDX_W;

  typedef struct packed {
    logic [31:0]          lhs;
    logic [31:0]          rhs;
    logic                 is_divide;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  entry_t                 mem [MEM_D];
  entry_t                 head;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_next;
  logic [PTR_W-1:0]       rd_next;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   ready_q;

  state_t                 state;
  state_t                 state_next;
  logic                   discard;
  logic [TAG_WIDTH-1:0]   busy_tag;
  logic                   cap_div;
  logic                   cap_fast;
  logic                   set_discard;
  logic                   clr_out;
  logic                   special_hit;
  logic [31:0]            special_result;

  assign empty         = (wr_ptr == rd_ptr);
  assign push          = in_valid & ready_q & ~flush;
  assign in_ready      = ready_q;
  assign head          = mem[IDX_W'(rd_ptr)];
  assign div_lhs       = head.lhs;
  assign div_rhs       = head.rhs;
  assign div_is_divide = head.is_divide;

  // Flush collapses the read pointer onto the write pointer.
  always_comb begin
    wr_next = wr_ptr + PTR_W'(push);
    rd_next = flush ? wr_ptr : (rd_ptr + PTR_W'(pop));
  end

  // Ready is precomputed from the next pointers so it never depends on a same-cycle pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_next;
      rd_ptr  <= rd_next;
      ready_q <= ((wr_next - rd_next) != PTR_W'(QUEUE_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[IDX_W'(wr_ptr)] <= '{lhs: in_lhs, rhs: in_rhs, is_divide: in_is_divide, tag: in_tag};
    end
  end

`ifdef FP_DIV_SQRT_FAST_SPECIAL_EN
  logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, q_sign;

  assign a_nan  = (head.lhs[30:23] == 8'hff) && (head.lhs[22:0] != 23'd0);
  assign a_inf  = (head.lhs[30:23] == 8'hff) && (head.lhs[22:0] == 23'd0);
  assign a_zero = (head.lhs[30:0] == 31'd0);
  assign b_nan  = (head.rhs[30:23] == 8'hff) && (head.rhs[22:0] != 23'd0);
  assign b_inf  = (head.rhs[30:23] == 8'hff) && (head.rhs[22:0] == 23'd0);
  assign b_zero = (head.rhs[30:0] == 31'd0);
  assign q_sign = head.lhs[31] ^ head.rhs[31];

  // Results match the divider bit for bit, so the local path is invisible to writeback.
  always_comb begin
    special_hit    = 1'b0;
    special_result = '0;
    if (head.is_divide) begin
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
        special_hit    = 1'b1;
        special_result = 32'h7fc0_0000;
      end else if (a_inf || b_zero) begin
        special_hit    = 1'b1;
        special_result = {q_sign, 8'hff, 23'd0};
      end else if (a_zero || b_inf) begin
        special_hit    = 1'b1;
        special_result = {q_sign, 31'd0};
      end
    end else begin
      if (a_nan || (head.lhs[31] && !a_zero)) begin
        special_hit    = 1'b1;
        special_result = 32'h7fc0_0000;
      end else if (a_zero || a_inf) begin
        special_hit    = 1'b1;
        special_result = head.lhs;
      end
    end
  end
`else
  assign special_hit    = 1'b0;
  assign special_result = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!flush && !empty) begin
          if (special_hit) begin
            state_next = HOLD;
          end else if (div_finished) begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (div_finished) begin
          state_next = (discard || flush) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (flush || out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The launch cycle is spent in IDLE, so BUSY only ever sees the divider's own completion.
  always_comb begin
    div_req     = 1'b0;
    pop         = 1'b0;
    cap_div     = 1'b0;
    cap_fast    = 1'b0;
    set_discard = 1'b0;
    clr_out     = flush;
    case (state)
      IDLE: begin
        if (!flush && !empty) begin
          if (special_hit) begin
            pop      = 1'b1;
            cap_fast = 1'b1;
          end else if (div_finished) begin
            pop     = 1'b1;
            div_req = 1'b1;
          end
        end
      end
      BUSY: begin
        set_discard = flush;
        cap_div     = div_finished & ~discard & ~flush;
      end
      HOLD: begin
        clr_out = flush | out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      discard    <= 1'b0;
      busy_tag   <= '0;
    end else begin
      if (div_req) begin
        busy_tag <= head.tag;
        discard  <= 1'b0;
      end else if (set_discard) begin
        discard <= 1'b1;
      end
      if (cap_div) begin
        out_valid  <= 1'b1;
        out_result <= div_result;
        out_tag    <= busy_tag;
      end else if (cap_fast) begin
        out_valid  <= 1'b1;
        out_result <= special_result;
        out_tag    <= head.tag;
      end else if (clr_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_sqrt_issue_ctrl.sv
// Bench for fp_div_sqrt_issue_ctrl: behavioural divider, in-order scoreboard, directed and random steps.
module tb_fp_div_sqrt_issue_ctrl;
  localparam int unsigned QD = 2;
  localparam int unsigned TW = 6;
  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_lhs;
  logic [31:0]   in_rhs;
  logic          in_is_divide;
  logic [TW-1:0] in_tag;
  logic          flush;
  logic          div_req;
  logic [31:0]   div_lhs;
  logic [31:0]   div_rhs;
  logic          div_is_divide;
  logic          div_finished;
  logic [31:0]   div_result;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [TW-1:0] out_tag;

  fp_div_sqrt_issue_ctrl #(.QUEUE_DEPTH(QD), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_lhs(in_lhs), .in_rhs(in_rhs), .in_is_divide(in_is_divide), .in_tag(in_tag),
    .flush(flush), .div_req(div_req), .div_lhs(div_lhs), .div_rhs(div_rhs),
    .div_is_divide(div_is_divide), .div_finished(div_finished), .div_result(div_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference FP32 divide/sqrt: IEEE special cases plus a few exact values; other inputs map to a fixed scramble.
  function automatic logic [31:0] div_fn(input logic [31:0] a, input logic [31:0] b, input logic d);
    logic an, ai, az, bn, bi, bz, s;
    an = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    ai = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    az = (a[30:0] == 31'd0);
    bn = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    bi = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    bz = (b[30:0] == 31'd0);
    s  = a[31] ^ b[31];
    if (d) begin
      if (an || bn || (az && bz) || (ai && bi)) return QNAN;
      if (ai || bz) return {s, 8'hff, 23'd0};
      if (az || bi) return {s, 31'd0};
      if (a == 32'h40c0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      if (a == 32'h3f80_0000 && b == 32'h4040_0000) return 32'h3eaa_aaab;
      return a ^ {b[15:0], b[31:16]};
    end
    if (an || (a[31] && !az)) return QNAN;
    if (az || ai) return a;
    if (a == 32'h4080_0000) return 32'h4000_0000;
    return a ^ 32'h5a5a_a5a5;
  endfunction

  // Divider model: finished drops after req and is high again in the 16th (divide) / 15th (sqrt) cycle counting the req cycle.
  logic        dbusy;
  int          dcnt;
  logic [31:0] dres;
  int          nreq = 0;
  int          proto_err = 0;

  always @(posedge clk) begin
    if (!rst) begin
      dbusy <= 1'b0;
      dcnt  <= 0;
    end else if (div_req) begin
      if (dbusy) proto_err <= proto_err + 1;
      dbusy <= 1'b1;
      dcnt  <= div_is_divide ? 13 : 12;
      dres  <= div_fn(div_lhs, div_rhs, div_is_divide);
      nreq  <= nreq + 1;
    end else if (dbusy) begin
      if (dcnt == 0) dbusy <= 1'b0;
      else dcnt <= dcnt - 1;
    end
  end
  assign div_finished = ~dbusy;
  assign div_result   = dres;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   res;
  } want_t;

  want_t         want_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic          prev_f = 1'b0;
  logic [TW-1:0] prev_tag = '0;
  logic [31:0]   prev_res = '0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, want);
    end
  endtask

  // One clock: scoreboard and hold-stability checks on the falling edge, then step past the rising edge.
  task automatic tick();
    want_t w;
    @(negedge clk);
    if (!rst) begin
      want_q.delete();
    end else begin
      if (prev_v && !prev_r && !prev_f)
        chk("hold_stable", 64'({out_valid, out_tag, out_result}), 64'({1'b1, prev_tag, prev_res}));
      if (flush) begin
        want_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          chk("out_expected", 64'(want_q.size() != 0), 64'd1);
          if (want_q.size() != 0) begin
            w = want_q.pop_front();
            chk("out_data", 64'({out_tag, out_result}), 64'({w.tag, w.res}));
          end
        end
        if (in_valid && in_ready)
          want_q.push_back('{tag: in_tag, res: div_fn(in_lhs, in_rhs, in_is_divide)});
      end
    end
    prev_v   = out_valid & rst;
    prev_r   = out_ready;
    prev_f   = flush;
    prev_tag = out_tag;
    prev_res = out_result;
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic d, input logic [TW-1:0] tg, input int lat,
                            input logic [31:0] res);
    int n;
    chk({name, "_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_lhs = a; in_rhs = b; in_is_divide = d; in_tag = tg; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, 64'(n + 1), 64'(lat));
    chk({name, "_result"}, 64'({out_tag, out_result}), 64'({tg, res}));
    tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7f80_0000;
      3: return 32'hff80_0000;
      4: return 32'h7fc0_0001;
      5: return 32'hbf80_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    int ov;
    rst = 1'b0; in_valid = 1'b0; in_lhs = '0; in_rhs = '0; in_is_divide = 1'b0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    repeat (3) tick();
    chk("reset_in_ready_low", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_div_req", 64'(div_req), 64'd0);
    chk("reset_out_result", 64'(out_result), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);

    run_single("div6_2", 32'h40c0_0000, 32'h4000_0000, 1'b1, 6'd5, 17, 32'h4040_0000);
    run_single("sqrt4", 32'h4080_0000, 32'h0, 1'b0, 6'd9, 16, 32'h4000_0000);
    run_single("div1_3", 32'h3f80_0000, 32'h4040_0000, 1'b1, 6'd3, 17, 32'h3eaa_aaab);

    r0 = nreq;
`ifdef FP_DIV_SQRT_FAST_SPECIAL_EN
    run_single("div_by_zero", 32'h3f80_0000, 32'h0, 1'b1, 6'd11, 2, 32'h7f80_0000);
    run_single("sqrt_neg", 32'hbf80_0000, 32'h0, 1'b0, 6'd12, 2, QNAN);
    chk("special_req_count", 64'(nreq - r0), 64'd0);
`else
    run_single("div_by_zero", 32'h3f80_0000, 32'h0, 1'b1, 6'd11, 17, 32'h7f80_0000);
    run_single("sqrt_neg", 32'hbf80_0000, 32'h0, 1'b0, 6'd12, 16, QNAN);
    chk("special_req_count", 64'(nreq - r0), 64'd2);
`endif

    // Fill: one op goes to the divider, QD more fill the queue, the next is refused.
    out_ready = 1'b0;
    for (int k = 0; k <= int'(QD) + 1; k++) begin
      in_valid = 1'b1; in_lhs = 32'h4000_0000 + 32'(k); in_rhs = 32'h3f80_0001;
      in_is_divide = 1'b1; in_tag = TW'(20 + k);
      chk($sformatf("fill_ready_%0d", k), 64'(in_ready), 64'(k <= int'(QD)));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk("fill_refused", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    repeat (25) tick();
    chk("fill_head", 64'({out_valid, out_tag}), 64'({1'b1, 6'd20}));
    chk("fill_still_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    n = 0;
    while (want_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("fill_drained", 64'(want_q.size()), 64'd0);

    // Flush four cycles after launch with one op still queued.
    in_valid = 1'b1; in_lhs = 32'h3f80_0000; in_rhs = 32'h4040_0000; in_is_divide = 1'b1; in_tag = 6'd30;
    tick();
    in_lhs = 32'h4080_0000; in_is_divide = 1'b0; in_tag = 6'd31;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_empty", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_lhs = 32'h40c0_0000; in_rhs = 32'h4000_0000; in_is_divide = 1'b1; in_tag = 6'd33;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 80) begin
      tick();
      n++;
    end
    chk("flush_new_op", 64'({out_tag, out_result}), 64'({6'd33, 32'h4040_0000}));
    tick();

    // Reset in the middle of a divide drops everything.
    in_valid = 1'b1; in_lhs = 32'h3f80_0000; in_rhs = 32'h4040_0000; in_is_divide = 1'b1; in_tag = 6'd40;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    ov = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) ov++;
      tick();
    end
    chk("rst_mid_no_out", 64'(ov), 64'd0);
    run_single("after_rst", 32'h40c0_0000, 32'h4000_0000, 1'b1, 6'd41, 17, 32'h4040_0000);

    // Random traffic with random backpressure and occasional flush.
    for (int i = 0; i < 500; i++) begin
      in_valid     = ($urandom_range(0, 2) != 0);
      in_lhs       = pick();
      in_rhs       = pick();
      in_is_divide = $urandom_range(0, 1) != 0;
      in_tag       = TW'($urandom());
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 59) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    n = 0;
    while (want_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("random_drained", 64'(want_q.size()), 64'd0);
    repeat (20) tick();
    chk("random_idle_ready", 64'(in_ready), 64'd1);
    chk("div_protocol", 64'(proto_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
